// File: rtl/gate_truth_table_checker.sv
// Gate self-test sequencer: sweeps every input row into a gate under test,
// waits for the output to settle, and scores it against a truth table.
module gate_truth_table_checker #(
  parameter int                         NUM_INPUTS     = 1,
  parameter logic [2**NUM_INPUTS-1:0]   EXPECTED_TABLE = 2'b01,
  parameter int                         SETTLE_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [NUM_INPUTS-1:0] stimulusOut,
  input  logic                  gateResponse,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_INPUTS:0]   failCount,
  output logic [NUM_INPUTS-1:0] firstFailRow,
  output logic                  firstFailValid
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [NUM_INPUTS-1:0] LAST_ROW = '1;
  localparam logic [NUM_INPUTS-1:0] ROW_ONE  = NUM_INPUTS'(1);
  localparam logic [NUM_INPUTS:0]   CNT_ONE  = (NUM_INPUTS+1)'(1);
  localparam logic [3:0]            SET_LAST = 4'(SETTLE_CYCLES - 1);

  state_t                state_q, state_d;
  logic [NUM_INPUTS-1:0] row_q, row_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [NUM_INPUTS:0]   fcnt_q, fcnt_d;
  logic [NUM_INPUTS-1:0] ffrow_q, ffrow_d;
  logic                  ffval_q, ffval_d;
  logic                  mismatch;

  assign mismatch = gateResponse != EXPECTED_TABLE[row_q];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fcnt_d  = fcnt_q;
    ffrow_d = ffrow_q;
    ffval_d = ffval_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          row_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fcnt_d  = '0;
          ffrow_d = '0;
          ffval_d = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == SET_LAST) state_d = SAMPLE;
        else cnt_d = cnt_q + 4'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          fcnt_d = fcnt_q + CNT_ONE;
          if (!ffval_q) begin
            ffrow_d = row_q;
            ffval_d = 1'b1;
          end
        end
        // pass must reflect the last row's compare, so use the next count
        if (row_q == LAST_ROW) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (fcnt_d == '0);
        end else begin
          state_d = DRIVE;
          row_d   = row_q + ROW_ONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fcnt_q  <= '0;
      ffrow_q <= '0;
      ffval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fcnt_q  <= fcnt_d;
      ffrow_q <= ffrow_d;
      ffval_q <= ffval_d;
    end
  end

  assign stimulusOut    = row_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign failCount      = fcnt_q;
  assign firstFailRow   = ffrow_q;
  assign firstFailValid = ffval_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: one-input checker (NOT table) and two-input checker
// (NAND table) driven against small behavioural gate models.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // one-input instance: NOT table, settle 2
  logic       rst1, start1, resp1, inv_ok;
  logic [0:0] stim1, ffrow1;
  logic [1:0] fcnt1;
  logic       busy1, done1, pass1, ffv1;

  // two-input instance: NAND table, settle 1
  logic       rst2, start2, resp2, nand_mode;
  logic [1:0] stim2, ffrow2;
  logic [2:0] fcnt2;
  logic       busy2, done2, pass2, ffv2;

  assign resp1 = inv_ok ? ~stim1[0] : 1'b0;
  assign resp2 = nand_mode ? ~(stim2[0] & stim2[1]) : (stim2[0] & stim2[1]);

  gate_truth_table_checker #(
    .NUM_INPUTS(1), .EXPECTED_TABLE(2'b01), .SETTLE_CYCLES(2)
  ) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .stimulusOut(stim1),
    .gateResponse(resp1), .busy(busy1), .done(done1), .pass(pass1),
    .failCount(fcnt1), .firstFailRow(ffrow1), .firstFailValid(ffv1)
  );

  gate_truth_table_checker #(
    .NUM_INPUTS(2), .EXPECTED_TABLE(4'b0111), .SETTLE_CYCLES(1)
  ) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .stimulusOut(stim2),
    .gateResponse(resp2), .busy(busy2), .done(done2), .pass(pass2),
    .failCount(fcnt2), .firstFailRow(ffrow2), .firstFailValid(ffv2)
  );

  task automatic test_reset;
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    inv_ok = 1'b1; nand_mode = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({stim1, busy1, done1, pass1, fcnt1, ffrow1, ffv1} !== 8'd0) begin
      failures++;
      $display("FAIL reset1 got=%b want=0",
               {stim1, busy1, done1, pass1, fcnt1, ffrow1, ffv1});
    end
    checks++;
    if ({stim2, busy2, done2, pass2, fcnt2, ffrow2, ffv2} !== 11'd0) begin
      failures++;
      $display("FAIL reset2 got=%b want=0",
               {stim2, busy2, done2, pass2, fcnt2, ffrow2, ffv2});
    end
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_inverter_ok;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (stim1 !== ((c <= 3) ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL t1_stim cyc=%0d got=%b want=%b", c, stim1, (c > 3));
      end
      checks++;
      if (done1 !== (c == 7) || busy1 !== 1'b1) begin
        failures++;
        $display("FAIL t1_done cyc=%0d done=%b busy=%b want done=%b busy=1",
                 c, done1, busy1, (c == 7));
      end
      if (c != 7) @(negedge clk);
    end
    checks++;
    if ({pass1, fcnt1, ffv1} !== 4'b1_00_0) begin
      failures++;
      $display("FAIL t1_result got p/f/v=%b want=1000", {pass1, fcnt1, ffv1});
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || stim1 !== 1'b1) begin
      failures++;
      $display("FAIL t1_after busy=%b done=%b stim=%b want 0 0 1",
               busy1, done1, stim1);
    end
  endtask

  task automatic test_stuck_at_0;
    bit seen = 0;
    inv_ok = 1'b0;
    start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (done1 === 1'b1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL t2_timeout got done=0 want done within 40 cycles");
    end
    checks++;
    if ({pass1, fcnt1, ffrow1, ffv1} !== 5'b0_01_0_1) begin
      failures++;
      $display("FAIL t2_result got p/f/r/v=%b want=00101",
               {pass1, fcnt1, ffrow1, ffv1});
    end
    inv_ok = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nand_vs_and;
    nand_mode = 1'b0;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (done2 !== (c == 9)) begin
        failures++;
        $display("FAIL t3_done cyc=%0d got=%b want=%b", c, done2, (c == 9));
      end
      if (c != 9) @(negedge clk);
    end
    checks++;
    if ({pass2, fcnt2, ffrow2, ffv2} !== 7'b0_100_00_1) begin
      failures++;
      $display("FAIL t3_result got p/f/r/v=%b want=0100001",
               {pass2, fcnt2, ffrow2, ffv2});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_start;
    nand_mode = 1'b1;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 1) begin
        checks++;
        if (fcnt2 !== 3'd0 || ffv2 !== 1'b0) begin
          failures++;
          $display("FAIL t4_clear fcnt=%0d v=%b want 0 0", fcnt2, ffv2);
        end
      end
      checks++;
      if (busy2 !== (c <= 9) || done2 !== (c == 9)) begin
        failures++;
        $display("FAIL t4_busy cyc=%0d busy=%b done=%b want %b %b",
                 c, busy2, done2, (c <= 9), (c == 9));
      end
      if (c == 9) begin
        checks++;
        if (pass2 !== 1'b1 || fcnt2 !== 3'd0) begin
          failures++;
          $display("FAIL t4_pass got pass=%b fcnt=%0d want 1 0", pass2, fcnt2);
        end
      end
      start2 = (c == 3 || c == 9);
      @(negedge clk);
    end
    start2 = 1'b0;
  endtask

  task automatic test_start_held;
    inv_ok = 1'b0;
    start1 = 1'b1; @(negedge clk);
    for (int c = 1; c <= 15; c++) begin
      if (c == 7) begin
        checks++;
        if (done1 !== 1'b1 || fcnt1 !== 2'd1 || pass1 !== 1'b0) begin
          failures++;
          $display("FAIL t5_sweep1 done=%b fcnt=%0d pass=%b want 1 1 0",
                   done1, fcnt1, pass1);
        end
        inv_ok = 1'b1;
      end
      if (c == 8) begin
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
          failures++;
          $display("FAIL t5_idle busy=%b done=%b want 0 0", busy1, done1);
        end
      end
      if (c == 9) begin
        checks++;
        if (busy1 !== 1'b1 || fcnt1 !== 2'd0 || ffv1 !== 1'b0) begin
          failures++;
          $display("FAIL t5_restart busy=%b fcnt=%0d v=%b want 1 0 0",
                   busy1, fcnt1, ffv1);
        end
      end
      if (c == 15) begin
        checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || fcnt1 !== 2'd0) begin
          failures++;
          $display("FAIL t5_sweep2 done=%b pass=%b fcnt=%0d want 1 1 0",
                   done1, pass1, fcnt1);
        end
        start1 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_sweep;
    nand_mode = 1'b0;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (stim2 !== 2'd2 || fcnt2 !== 3'd2 || busy2 !== 1'b1) begin
      failures++;
      $display("FAIL t6_pre stim=%0d fcnt=%0d busy=%b want 2 2 1",
               stim2, fcnt2, busy2);
    end
    rst2 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    checks++;
    if ({stim2, busy2, done2, pass2, fcnt2, ffrow2, ffv2} !== 11'd0) begin
      failures++;
      $display("FAIL t6_rst got=%b want=0",
               {stim2, busy2, done2, pass2, fcnt2, ffrow2, ffv2});
    end
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      failures++;
      $display("FAIL t6_prio busy=%b done=%b want 0 0", busy2, done2);
    end
    rst2 = 1'b0; start2 = 1'b0; nand_mode = 1'b1;
    @(negedge clk);
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (done2 !== (c == 9)) begin
        failures++;
        $display("FAIL t6_sweep cyc=%0d done=%b want %b", c, done2, (c == 9));
      end
      if (c != 9) @(negedge clk);
    end
    checks++;
    if (pass2 !== 1'b1 || fcnt2 !== 3'd0) begin
      failures++;
      $display("FAIL t6_pass pass=%b fcnt=%0d want 1 0", pass2, fcnt2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_inverter_ok();
    test_stuck_at_0();
    test_nand_vs_and();
    test_back_to_back_start();
    test_start_held();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
